// File: rtl/pcs_gearbox_tx.sv
// 66b->64b transmit gearbox: packs {payload, sync header} blocks into a continuous
// 64-bit SERDES word stream, taking one stall cycle every 33 to absorb the header bits.
module pcs_gearbox_tx #(
  parameter int HEAD_W = 2,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              head_err_o,
  output logic [5:0]        seq_o
);

  localparam int         SEQ_N    = DATA_W / HEAD_W + 1;
  localparam logic [5:0] SEQ_LAST = 6'(SEQ_N - 1);

  // Handshake: upstream always presents a block and holds it until ready_o is
  // high; a block is consumed on every rising edge where ready_o is high.
  logic [5:0]               seq_q;
  logic [DATA_W-1:0]        res_q;
  logic [DATA_W+HEAD_W-1:0] blk;
  logic [6:0]               r;
  logic [DATA_W-1:0]        res_mask;
  logic [DATA_W-1:0]        data_nxt;
  logic [DATA_W-1:0]        res_nxt;
  logic                     err_nxt;
  logic [5:0]               seq_nxt;

  assign blk      = {data_i, head_i};
  assign r        = {seq_q, 1'b0};
  assign res_mask = (64'd1 << r) - 64'd1;
  assign ready_o  = ~reset & (seq_q != SEQ_LAST);
  assign seq_o    = seq_q;
  assign seq_nxt  = (seq_q == SEQ_LAST) ? 6'd0 : seq_q + 6'd1;

  // Residual holds 2*seq bits; the stall cycle flushes exactly one full word of it.
  always_comb begin
    data_nxt = res_q;
    res_nxt  = '0;
    err_nxt  = 1'b0;
    if (seq_q != SEQ_LAST) begin
      data_nxt = (blk[DATA_W-1:0] << r) | (res_q & res_mask);
      res_nxt  = 64'(blk >> (7'd64 - r));
      err_nxt  = ~(head_i[0] ^ head_i[1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q      <= '0;
      res_q      <= '0;
      data_o     <= '0;
      head_err_o <= 1'b0;
    end else begin
      seq_q      <= seq_nxt;
      res_q      <= res_nxt;
      data_o     <= data_nxt;
      head_err_o <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pcs_gearbox_tx.sv
// Self-checking bench for pcs_gearbox_tx: a bit-queue stream model predicts every
// output word, ready and header-error pulse from the 66-bit blocks driven in.
module tb_pcs_gearbox_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  head_i = 2'b01;
  logic [63:0] data_i = '0;
  logic        ready_o;
  logic [63:0] data_o;
  logic        head_err_o;
  logic [5:0]  seq_o;

  pcs_gearbox_tx dut (
    .clk        (clk),
    .reset      (reset),
    .head_i     (head_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .data_o     (data_o),
    .head_err_o (head_err_o),
    .seq_o      (seq_o)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic        bit_q[$];
  logic [63:0] exp_q[$];
  int          k = 0;
  logic        exp_err = 1'b0;
  logic        last_cons = 1'b0;
  int          stalls = 0;
  int          cons = 0;
  int          errs = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check ready, advance the stream model, check outputs.
  task automatic cycle(input logic rst, input logic [1:0] h, input logic [63:0] d);
    logic [65:0] blk;
    logic [63:0] w;
    logic        cons_now;
    logic        rdy_obs;
    @(negedge clk);
    reset  = rst;
    head_i = h;
    data_i = d;
    #1;
    cons_now = !rst && (k != 32);
    rdy_obs  = ready_o;
    chk("ready", {63'd0, rdy_obs}, {63'd0, cons_now});
    blk = {d, h};
    w   = '0;
    if (rst) begin
      bit_q.delete();
      exp_err = 1'b0;
      k = 0;
    end else begin
      if (cons_now)
        for (int i = 0; i < 66; i++) bit_q.push_back(blk[i]);
      for (int i = 0; i < 64; i++)
        w[i] = (bit_q.size() > 0) ? bit_q.pop_front() : 1'b0;
      exp_err = cons_now && (h == 2'b00 || h == 2'b11);
      k = (k == 32) ? 0 : k + 1;
    end
    exp_q.push_back(w);
    @(posedge clk);
    #1;
    chk("data", data_o, exp_q.pop_front());
    chk("head_err", {63'd0, head_err_o}, {63'd0, exp_err});
    chk("seq", {58'd0, seq_o}, 64'(k));
    last_cons = cons_now;
    if (!rst && rdy_obs) cons++;
    if (!rst && !rdy_obs) stalls++;
    if (head_err_o) errs++;
  endtask

  // Present one block and hold it until it is consumed (at most one stall).
  task automatic run_blk(input logic [1:0] h, input logic [63:0] d);
    cycle(1'b0, h, d);
    if (!last_cons) cycle(1'b0, h, d);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [1:0] rnd_head();
    logic b;
    b = 1'($urandom_range(0, 1));
    return {b, ~b};
  endfunction

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 2'($urandom_range(0, 3)), rnd64());
  endtask

  initial begin
    logic [1:0]  h;
    logic [63:0] d;

    // Held reset with changing inputs: everything stays quiet.
    do_reset(5);

    // Directed first word after release.
    run_blk(2'b01, 64'h0123_4567_89AB_CDEF);
    chk("dir_word", data_o, 64'h048D_159E_26AF_37BD);

    // Random stream over 330 cycles from a fresh period.
    do_reset(1);
    stalls = 0;
    cons = 0;
    for (int i = 0; i < 330; i++) cycle(1'b0, rnd_head(), rnd64());
    chk("stall_count", 64'(stalls), 64'd10);
    chk("consume_count", 64'(cons), 64'd320);

    // Control blocks alternating all-zeros/all-ones payload; block 31 is all-ones.
    do_reset(1);
    for (int b = 0; b < 32; b++) run_blk(2'b10, (b % 2 == 0) ? 64'h0 : {64{1'b1}});
    chk("pre_stall_word", data_o, 64'h8000_0000_0000_0000);
    cycle(1'b0, 2'b10, 64'h0);
    chk("stall_word", data_o, {64{1'b1}});

    // Invalid headers at blocks 5 and 31.
    do_reset(1);
    errs = 0;
    for (int b = 0; b < 40; b++) begin
      h = (b == 5) ? 2'b00 : (b == 31) ? 2'b11 : rnd_head();
      run_blk(h, rnd64());
    end
    chk("err_pulses", 64'(errs), 64'd2);

    // Single-cycle reset mid-period at seq 17, then realign.
    do_reset(1);
    for (int b = 0; b < 17; b++) run_blk(rnd_head(), rnd64());
    chk("at_seq17", {58'd0, seq_o}, 64'd17);
    cycle(1'b1, rnd_head(), rnd64());
    chk("rst17_data", data_o, 64'd0);
    h = rnd_head();
    d = rnd64();
    run_blk(h, d);
    chk("post_rst_word", data_o, {d[61:0], h});
    for (int b = 0; b < 40; b++) run_blk(rnd_head(), rnd64());

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
